// File: rtl/operand_issue_stage.sv
// Operand-fetch / issue stage sitting between instruction fetch and the ALU.
// Decodes a 16-bit instruction, reads an 8x8 register file, and hands a
// registered (a, b, alu_op, op_rd) bundle to the ALU over valid/ready.
// A per-register scoreboard tracks destinations whose results are still in
// flight and stalls issue on RAW and WAW hazards.
//
// Build option: define OPERAND_BYPASS_EN to forward a same-cycle writeback
// straight into the operand mux, which removes the RAW stall for that case.

module operand_issue_stage #(
  parameter int NREGS = 8,
  parameter int DW    = 8,
  parameter int IW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  input  logic [IW-1:0]            instr,
  output logic                     instr_ready,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [DW-1:0]            a,
  output logic [DW-1:0]            b,
  output logic [3:0]               alu_op,
  output logic [$clog2(NREGS)-1:0] op_rd,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [DW-1:0]            wb_data
);

  localparam int         AW         = $clog2(NREGS);
  localparam logic [3:0] OPCODE_LDI = 4'hF;

  // Decoded view of the instruction word.
  typedef struct packed {
    logic [3:0]    opcode;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          is_ldi;
    logic [DW-1:0] imm;
  } dec_t;

  dec_t              dec;
  logic [DW-1:0]     regs [NREGS];
  logic [NREGS-1:0]  pending;
  logic [NREGS-1:0]  pending_nxt;
  logic [DW-1:0]     rs1_val;
  logic [DW-1:0]     rs2_val;
  logic              rs1_fwd;
  logic              rs2_fwd;
  logic              raw_hazard;
  logic              waw_hazard;
  logic              issue;
  logic [DW-1:0]     opnd_a;
  logic [DW-1:0]     opnd_b;

  // Field extraction; LDI reuses the low byte as its immediate.
  always_comb begin
    dec.opcode = instr[15:12];
    dec.rd     = instr[11:9];
    dec.rs1    = instr[8:6];
    dec.rs2    = instr[5:3];
    dec.is_ldi = (instr[15:12] == OPCODE_LDI);
    dec.imm    = instr[DW-1:0];
  end

  // Combinational register read with r0 forced to zero and optional forwarding.
  always_comb begin
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    rs1_val = (dec.rs1 == '0) ? '0 : regs[dec.rs1];
    rs2_val = (dec.rs2 == '0) ? '0 : regs[dec.rs2];
`ifdef OPERAND_BYPASS_EN
    rs1_fwd = wb_en && (wb_addr == dec.rs1) && (dec.rs1 != '0);
    rs2_fwd = wb_en && (wb_addr == dec.rs2) && (dec.rs2 != '0);
`else
    rs1_fwd = 1'b0;
    rs2_fwd = 1'b0;
`endif
    if (rs1_fwd) rs1_val = wb_data;
    if (rs2_fwd) rs2_val = wb_data;
  end

  // Hazard detection and the upstream handshake.
  always_comb begin
    // LDI reads no source registers, so only its destination can collide.
    raw_hazard  = !dec.is_ldi &&
                  ((pending[dec.rs1] && !rs1_fwd) ||
                   (pending[dec.rs2] && !rs2_fwd));
    waw_hazard  = pending[dec.rd];
    instr_ready = reset && (!op_valid || op_ready) && !raw_hazard && !waw_hazard;
    issue       = instr_valid && instr_ready;
  end

  // Operand selection for the output register.
  always_comb begin
    opnd_a = dec.is_ldi ? '0      : rs1_val;
    opnd_b = dec.is_ldi ? dec.imm : rs2_val;
  end

  // Scoreboard next state: writeback clears, issue sets, r0 never pending.
  always_comb begin
    pending_nxt = pending;
    if (wb_en) pending_nxt[wb_addr] = 1'b0;
    if (issue) pending_nxt[dec.rd]  = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset) pending <= '0;
    else        pending <= pending_nxt;
  end

  // Register file write port; r0 is never written.
  always_ff @(posedge clk) begin
    // NOTE: this storage is architectural state that must read as zero after
    // reset, so it is cleared explicitly, which keeps it in flops rather than
    // a RAM macro.
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Output register toward the ALU: load on accept, hold under backpressure.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_valid <= 1'b0;
      a        <= '0;
      b        <= '0;
      alu_op   <= '0;
      op_rd    <= '0;
    end else if (issue) begin
      op_valid <= 1'b1;
      a        <= opnd_a;
      b        <= opnd_b;
      alu_op   <= dec.opcode;
      op_rd    <= dec.rd;
    end else if (op_ready) begin
      op_valid <= 1'b0;
    end
  end

endmodule

// File: doc/operand_issue_stage.md
Name: operand_issue_stage

Overview:
Operand-fetch and issue stage that sits directly upstream of the ALU and directly downstream of the program counter and instruction fetch. It decodes a 16-bit instruction and reads an 8-register by 8-bit register file. It then presents a registered operand pair (a, b) plus an opcode to the ALU through a valid/ready handshake. It consumes the ALU result back through a writeback port and tracks pending destination registers with a scoreboard, stalling on data hazards.

Parameters:
NREGS, 8, number of architectural registers; r0 is hardwired to zero.
DW, 8, data width; matches the ALU a, b and alu_result width.
IW, 16, instruction width.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk
instr_valid  input  1  fetch presents a valid instruction
instr  input  16  instruction word
instr_ready  output  1  stage accepts instr this cycle
op_valid  output  1  a, b, alu_op and op_rd are valid toward the ALU
op_ready  input  1  ALU consumes the operands this cycle
a  output  8  ALU operand A
b  output  8  ALU operand B
alu_op  output  4  ALU operation code
op_rd  output  3  destination register; travels with the op and returns as wb_addr
wb_en  input  1  writeback strobe from the ALU stage
wb_addr  input  3  writeback register index
wb_data  input  8  writeback data (alu_result)

Behaviour:
- Instruction format:
  - [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] ignored.
  - opcode 4'hF is LDI: a=8'h00, b=instr[7:0], rs1 and rs2 are not read.
- alu_op carries opcode[3:0] unchanged; for LDI the ALU performs ADD.
- Register file:
  - Reads are combinational.
  - Writes occur on the rising edge when wb_en=1 and wb_addr!=0.
  - Reads of r0 always return 0.
- Scoreboard:
  - One pending bit per register; r0 is never pending.
  - A bit is set on issue (instr_valid && instr_ready) for rd!=0.
  - A bit is cleared on wb_en for wb_addr.
- Hazard, combinational from instr:
  - RAW: rs1 or rs2 is pending. LDI ignores rs fields.
  - WAW: rd is pending.
- instr_ready = (!op_valid || op_ready) && !hazard. It is deasserted while reset is low.
- Issue timing: the output register loads a, b, alu_op and op_rd on the accept edge. op_valid rises 1 cycle after acceptance, so latency is 1 cycle.
- Handshake rules:
  - While op_valid=1 and op_ready=0, a, b, alu_op and op_rd hold stable.
  - op_valid drops after a transfer when no new accept occurs in the same cycle.
  - Back-to-back issue at 1 op/cycle when op_ready stays high and there is no hazard.
- Simultaneous events:
  - Writeback to a register in the same cycle it is read returns the OLD value unless ELSE BYPASS (see Optional Feature); without bypass the RAW stall covers it.
  - Set and clear of the same pending bit cannot coincide, because WAW stalls issue while rd is pending.
  - wb_en with wb_addr=0 is ignored.
- Reset (reset=0 at an edge):
  - All registers, pending bits, op_valid, a, b, alu_op and op_rd go to 0.
  - This applies mid-operation: an in-flight op is dropped, and a later writeback for a dropped op still writes the register file.

Optional Feature:
OPERAND_BYPASS_EN:
- Defined: if wb_en=1 in the accept cycle and wb_addr equals rs1 or rs2 (non-zero), wb_data is forwarded to a or b. That register is treated as not pending for the RAW check, so the instruction issues that same cycle instead of stalling.
- Undefined: no forwarding; the instruction stalls until the cycle after the writeback edge.

Test Plan:
- Reset hold: hold reset=0 for 2 cycles with instr_valid=1 -> instr_ready=0, op_valid=0, a=b=0; after release, instr_ready=1.
- LDI issue: LDI r1,8'h0A -> next cycle op_valid=1, a=8'h00, b=8'h0A, alu_op=4'hF, op_rd=1. wb r1=8'h0A; then LDI r2,8'h02, wb r2; then op 4'h1 r3,r1,r2 -> a=8'h0A, b=8'h02.
- RAW stall: issue 4'h1 r3,r1,r2, then immediately 4'h2 r4,r3,r1 -> instr_ready=0 until wb_en r3=8'h0C. Without bypass, issue occurs the cycle after wb with a=8'h0C; with bypass, issue occurs in the wb cycle with a=8'h0C.
- Backpressure: op_ready=0 for 3 cycles with op_valid=1 -> a, b, alu_op and op_rd remain stable and instr_ready=0. op_ready=1 -> transfer, then the next op is accepted.
- r0 and WAW:
  - wb_en with wb_addr=0, wb_data=8'hF2 -> r0 still reads 8'h00.
  - Issue to rd=5, then a second instruction with rd=5 -> stall until wb r5.
- Throughput: 4 independent LDI instructions with op_ready=1 -> op_valid high for 4 consecutive cycles, one op per cycle.
